// File: rtl/zbuffer.sv
// zbuffer: tri-state bus driver with clocked drive-status tracking.
//
// The data path is purely combinational. data_out carries data_in while
// enable is high and floats (all bits z) otherwise. It ignores clk and rst,
// so the bus stays under control of enable even while reset is held.
// The status section runs on clk and records drive activity for
// arbitration and debug logic elsewhere.
//
// Parameters:
//   DATASIZE  bus width in bits (default 8)
//   CNTSIZE   width of the saturating drive-cycle counter (default 8)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset, clears all status
//   enable     in   output enable, active-high
//   data_in    in   value to drive onto the bus
//   data_out   out  tri-state bus output
//   drive_q    out  enable, registered
//   hold_q     out  last value driven (captured on clocks with enable=1)
//   rise_p     out  one-cycle pulse when bus drive starts
//   fall_p     out  one-cycle pulse when bus is released
//   drive_cnt  out  saturating count of clocks sampled with enable=1

module zbuffer #(
    parameter int DATASIZE = 8,
    parameter int CNTSIZE  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [DATASIZE-1:0] data_in,
    output tri   [DATASIZE-1:0] data_out,
    output logic                drive_q,
    output logic [DATASIZE-1:0] hold_q,
    output logic                rise_p,
    output logic                fall_p,
    output logic [CNTSIZE-1:0]  drive_cnt
);

    assign data_out = enable ? data_in : {DATASIZE{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            drive_q   <= 1'b0;
            hold_q    <= '0;
            rise_p    <= 1'b0;
            fall_p    <= 1'b0;
            drive_cnt <= '0;
        end else begin
            drive_q <= enable;
            rise_p  <= enable & ~drive_q;
            fall_p  <= ~enable & drive_q;
            // An unknown enable fails this test, so it is not counted.
            if (enable) begin
                hold_q <= data_in;
                // Saturate at all-ones rather than wrapping.
                if (drive_cnt != {CNTSIZE{1'b1}}) begin
                    drive_cnt <= drive_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_zbuffer.sv
// Testbench for zbuffer (DATASIZE=4, CNTSIZE=3).
// Directed stimulus carries hand-computed expected status. After each clock
// edge the driver pushes that expectation into a queue. A separate monitor
// pops each entry on the following falling edge and compares it. A pullup on
// the bus makes a released bus read as all ones. The bus checks therefore
// drive data_in=0000 while disabled, so that a driven bus and a released bus
// read differently.

module tb_zbuffer;

    localparam int DW = 4;
    localparam int CW = 3;

    typedef struct {
        logic          dq;
        logic [DW-1:0] hold;
        logic          rise;
        logic          fall;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          clk_run;
    logic          rst;
    logic          enable;
    logic [DW-1:0] data_in;
    tri   [DW-1:0] data_out;
    logic          drive_q;
    logic [DW-1:0] hold_q;
    logic          rise_p;
    logic          fall_p;
    logic [CW-1:0] drive_cnt;

    int errors = 0;
    int checks = 0;
    exp_t sb_q[$];

    pullup pu (data_out);

    zbuffer #(.DATASIZE(DW), .CNTSIZE(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .data_in   (data_in),
        .data_out  (data_out),
        .drive_q   (drive_q),
        .hold_q    (hold_q),
        .rise_p    (rise_p),
        .fall_p    (fall_p),
        .drive_cnt (drive_cnt)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and queue the status expected after the edge.
    task automatic vec(input logic r, input logic en, input logic [DW-1:0] din,
                       input logic edq, input logic [DW-1:0] ehold,
                       input logic erise, input logic efall, input logic [CW-1:0] ecnt);
        exp_t e;
        @(negedge clk);
        rst     = r;
        enable  = en;
        data_in = din;
        @(posedge clk);
        #1;
        e.dq = edq; e.hold = ehold; e.rise = erise; e.fall = efall; e.cnt = ecnt;
        sb_q.push_back(e);
    endtask

    // Monitor: compares the status outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("drive_q",   32'(drive_q),   32'(e.dq));
                check("hold_q",    32'(hold_q),    32'(e.hold));
                check("rise_p",    32'(rise_p),    32'(e.rise));
                check("fall_p",    32'(fall_p),    32'(e.fall));
                check("drive_cnt", 32'(drive_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk_run = 1'b0;
        rst     = 1'b0;
        enable  = 1'b0;
        data_in = 4'b1111;

        // Combinational bus checks, with no clock running.
        #1; check("bus_off_1111", 32'(data_out), 32'hF);
        data_in = 4'b0000;
        #1; check("bus_off_released", 32'(data_out), 32'hF);
        data_in = 4'b1111; enable = 1'b1;
        #1; check("bus_on_1111", 32'(data_out), 32'hF);
        data_in = 4'b0000;
        #1; check("bus_on_0000", 32'(data_out), 32'h0);
        data_in = 4'b0101;
        #1; check("bus_on_follow", 32'(data_out), 32'h5);
        data_in = 4'b0000; enable = 1'b0;
        #1; check("bus_released", 32'(data_out), 32'hF);

        clk_run = 1'b1;

        // Reset for two edges.
        vec(1, 0, 4'h0, 0, 4'h0, 0, 0, 3'd0);
        vec(1, 0, 4'h0, 0, 4'h0, 0, 0, 3'd0);
        // Drive A, B, C for three edges, then release.
        vec(0, 1, 4'hA, 1, 4'hA, 1, 0, 3'd1);
        vec(0, 1, 4'hB, 1, 4'hB, 0, 0, 3'd2);
        vec(0, 1, 4'hC, 1, 4'hC, 0, 0, 3'd3);
        vec(0, 0, 4'h5, 0, 4'hC, 0, 1, 3'd3);
        vec(0, 0, 4'h6, 0, 4'hC, 0, 0, 3'd3);

        // Saturation: ten enabled edges; the counter stops at 7.
        vec(1, 0, 4'h0, 0, 4'h0, 0, 0, 3'd0);
        for (int i = 1; i <= 10; i++) begin
            vec(0, 1, 4'(i), 1, 4'(i), (i == 1), 0, (i > 7) ? 3'd7 : 3'(i));
        end
        vec(0, 0, 4'h0, 0, 4'hA, 0, 1, 3'd7);

        // Reset while driving with drive_cnt=5.
        vec(1, 0, 4'h0, 0, 4'h0, 0, 0, 3'd0);
        for (int i = 1; i <= 5; i++) begin
            vec(0, 1, 4'h3, 1, 4'h3, (i == 1), 0, 3'(i));
        end
        vec(1, 1, 4'h9, 0, 4'h0, 0, 0, 3'd0);
        check("bus_during_reset", 32'(data_out), 32'h9);
        vec(0, 1, 4'h4, 1, 4'h4, 1, 0, 3'd1);
        vec(0, 1, 4'h4, 1, 4'h4, 0, 0, 3'd2);

        // Single-cycle enable pulse: rise on n+1, fall on n+2.
        vec(0, 0, 4'h0, 0, 4'h4, 0, 1, 3'd2);
        vec(0, 1, 4'h2, 1, 4'h2, 1, 0, 3'd3);
        vec(0, 0, 4'h0, 0, 4'h2, 0, 1, 3'd3);
        vec(0, 0, 4'h0, 0, 4'h2, 0, 0, 3'd3);

        // Let the monitor drain the last entry.
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
